// File: rtl/tri_bbox_raster.sv
// -----------------------------------------------------------------------------
// tri_bbox_raster
//
// Rasterizes one triangle per start pulse. The three vertices arrive as signed
// Q16.15 fixed point. Their integer parts define a bounding box, which is
// clipped to the screen and scanned in row-major order. The block streams one
// packed {x,y} coordinate per covered pixel over a valid/ready handshake.
//
// Ports
//   CLOCK_50     in   1   clock, rising edge
//   RESET_N      in   1   asynchronous active-low reset
//   start        in   1   one-cycle start pulse, sampled only in IDLE
//   V0X..V2Y     in  32   vertex coordinates, signed Q16.15, latched on start
//   busy         out  1   high whenever the FSM is not IDLE
//   done         out  1   one-cycle pulse when the triangle is finished
//   coord_valid  out  1   coord holds a covered pixel
//   coord        out 18   {x[8:0], y[8:0]}
//   coord_ready  in   1   consumer accepts coord when coord_valid & coord_ready
// -----------------------------------------------------------------------------
module tri_bbox_raster #(
   parameter int H_RES     = 320,
   parameter int V_RES     = 240,
   parameter int FRAC_BITS = 15
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic        start,
   input  logic [31:0] V0X,
   input  logic [31:0] V0Y,
   input  logic [31:0] V1X,
   input  logic [31:0] V1Y,
   input  logic [31:0] V2X,
   input  logic [31:0] V2Y,
   output logic        busy,
   output logic        done,
   output logic        coord_valid,
   output logic [17:0] coord,
   input  logic        coord_ready
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_AREA, S_SCAN, S_EMIT, S_DONE
   } state_t;

   localparam logic signed [16:0] ZERO   = '0;
   localparam logic signed [16:0] X_LAST = 17'(H_RES - 1);
   localparam logic signed [16:0] Y_LAST = 17'(V_RES - 1);

   // Integer part of a Q16.15 value: arithmetic shift, kept as 17-bit signed.
   function automatic logic signed [16:0] to_int(input logic [31:0] v);
      return 17'($signed(v) >>> FRAC_BITS);
   endfunction

   function automatic logic signed [16:0] min3(input logic signed [16:0] a, b, c);
      logic signed [16:0] m;
      // NOTE: blocking assignments are correct here; this is combinational
      // scratch inside a function, not clocked state.
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic signed [16:0] max3(input logic signed [16:0] a, b, c);
      logic signed [16:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Edge function for edge a->b at point p. 18-bit differences cannot
   // overflow for 17-bit operands, nor can the 36-bit products or the 37-bit
   // difference of products.
   function automatic logic signed [36:0] edge_fn(
      input logic signed [16:0] ax, ay, bx, by, px, py
   );
      logic signed [17:0] dpx, dpy, dbx, dby;
      logic signed [35:0] p0, p1;
      dpx = {px[16], px} - {ax[16], ax};
      dpy = {py[16], py} - {ay[16], ay};
      dbx = {bx[16], bx} - {ax[16], ax};
      dby = {by[16], by} - {ay[16], ay};
      p0  = dpx * dby;
      p1  = dpy * dbx;
      return {p0[35], p0} - {p1[35], p1};
   endfunction

   state_t             r_state, w_next;
   logic [31:0]        r_vin [6];     // V0X, V0Y, V1X, V1Y, V2X, V2Y
   logic signed [16:0] r_xi  [3];
   logic signed [16:0] r_yi  [3];
   logic signed [16:0] r_xmin, r_xmax, r_ymin, r_ymax;
   logic signed [16:0] r_x, r_y;
   logic               r_flip;
   logic [17:0]        r_coord;

   logic signed [16:0] w_xi [3];
   logic signed [16:0] w_yi [3];
   logic signed [16:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
   logic signed [36:0] w_area;
   logic signed [36:0] w_e   [3];
   logic               w_inside;
   logic               w_box_empty;
   logic               w_last;
   logic               w_step;

   // ---------------------------------------------------------------- datapath
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_xi[i] = to_int(r_vin[2*i]);
         w_yi[i] = to_int(r_vin[2*i+1]);
      end
      w_lo_x = min3(w_xi[0], w_xi[1], w_xi[2]);
      w_hi_x = max3(w_xi[0], w_xi[1], w_xi[2]);
      w_lo_y = min3(w_yi[0], w_yi[1], w_yi[2]);
      w_hi_y = max3(w_yi[0], w_yi[1], w_yi[2]);
      if (w_lo_x < ZERO)   w_lo_x = ZERO;
      if (w_hi_x > X_LAST) w_hi_x = X_LAST;
      if (w_lo_y < ZERO)   w_lo_y = ZERO;
      if (w_hi_y > Y_LAST) w_hi_y = Y_LAST;
   end

   assign w_area = edge_fn(r_xi[0], r_yi[0], r_xi[1], r_yi[1], r_xi[2], r_yi[2]);

   always_comb begin
      w_e[0]   = edge_fn(r_xi[0], r_yi[0], r_xi[1], r_yi[1], r_x, r_y);
      w_e[1]   = edge_fn(r_xi[1], r_yi[1], r_xi[2], r_yi[2], r_x, r_y);
      w_e[2]   = edge_fn(r_xi[2], r_yi[2], r_xi[0], r_yi[0], r_x, r_y);
      w_inside = 1'b1;
      // Negating for clockwise triangles makes both windings cover the same
      // pixels, including pixels lying exactly on an edge.
      for (int i = 0; i < 3; i++) begin
         if (r_flip) w_e[i] = -w_e[i];
         if (w_e[i] < 0) w_inside = 1'b0;
      end
   end

   assign w_box_empty = (r_xmin > r_xmax) || (r_ymin > r_ymax);
   assign w_last      = (r_x >= r_xmax) && (r_y >= r_ymax);
   // Advance to the next pixel: outside pixel in SCAN, or accepted pixel in EMIT.
   assign w_step      = ((r_state == S_SCAN) && !w_inside) ||
                        ((r_state == S_EMIT) && coord_ready);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         // NOTE: the vertex array is a handful of flops, not a RAM, so it is
         // reset along with the rest of the state.
         for (int i = 0; i < 6; i++) r_vin[i] <= '0;
         for (int i = 0; i < 3; i++) begin
            r_xi[i] <= '0;
            r_yi[i] <= '0;
         end
         r_xmin  <= '0;
         r_xmax  <= '0;
         r_ymin  <= '0;
         r_ymax  <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_flip  <= 1'b0;
         r_coord <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_vin[0] <= V0X;
                  r_vin[1] <= V0Y;
                  r_vin[2] <= V1X;
                  r_vin[3] <= V1Y;
                  r_vin[4] <= V2X;
                  r_vin[5] <= V2Y;
               end
            end
            S_SETUP: begin
               for (int i = 0; i < 3; i++) begin
                  r_xi[i] <= w_xi[i];
                  r_yi[i] <= w_yi[i];
               end
               r_xmin <= w_lo_x;
               r_xmax <= w_hi_x;
               r_ymin <= w_lo_y;
               r_ymax <= w_hi_y;
            end
            S_AREA: begin
               r_flip <= (w_area < 0);
               r_x    <= r_xmin;
               r_y    <= r_ymin;
            end
            S_SCAN: begin
               if (w_inside) r_coord <= {r_x[8:0], r_y[8:0]};
            end
            default: ;
         endcase

         if (w_step) begin
            if (r_x < r_xmax) begin
               r_x <= r_x + 17'sd1;
            end else if (r_y < r_ymax) begin
               r_x <= r_xmin;
               r_y <= r_y + 17'sd1;
            end
         end
      end
   end

   // --------------------------------------------------------------------- FSM
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      w_next      = r_state;
      busy        = 1'b1;
      done        = 1'b0;
      coord_valid = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_SETUP;
         end
         S_SETUP: w_next = S_AREA;
         S_AREA: begin
            if ((w_area == 0) || w_box_empty) w_next = S_DONE;
            else                              w_next = S_SCAN;
         end
         S_SCAN: begin
            if (w_inside)    w_next = S_EMIT;
            else if (w_last) w_next = S_DONE;
         end
         S_EMIT: begin
            coord_valid = 1'b1;
            if (coord_ready) w_next = w_last ? S_DONE : S_SCAN;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign coord = r_coord;

endmodule

// File: tb/tb_tri_bbox_raster.sv
module tb_tri_bbox_raster;

   localparam int FRAC   = 15;
   localparam int BUDGET = 20000;

   logic        CLOCK_50;
   logic        RESET_N;
   logic        start;
   logic [31:0] V0X, V0Y, V1X, V1Y, V2X, V2Y;
   logic        busy, done, coord_valid, coord_ready;
   logic [17:0] coord;

   int          n_checks;
   int          n_errors;
   logic [17:0] exp_q[$];
   logic [17:0] got_q[$];
   logic [17:0] ref_q[$];
   int          done_cycle;

   tri_bbox_raster dut (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .start       (start),
      .V0X         (V0X),
      .V0Y         (V0Y),
      .V1X         (V1X),
      .V1Y         (V1Y),
      .V2X         (V2X),
      .V2Y         (V2Y),
      .busy        (busy),
      .done        (done),
      .coord_valid (coord_valid),
      .coord       (coord),
      .coord_ready (coord_ready)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   function automatic int fx(input int i);
      return i <<< FRAC;
   endfunction

   function automatic longint edge_val(input longint ax, ay, bx, by, px, py);
      return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
   endfunction

   // Reference: enumerate the clipped box and keep every pixel on the inner
   // side of all three edges (inner side chosen by the sign of the area).
   task automatic build_expected(input int ax, ay, bx, by, cx, cy);
      longint x0, y0, x1, y1, x2, y2, area, e0, e1, e2;
      longint lx, hx, ly, hy;
      logic [8:0] px, py;
      x0 = ax >>> FRAC; y0 = ay >>> FRAC;
      x1 = bx >>> FRAC; y1 = by >>> FRAC;
      x2 = cx >>> FRAC; y2 = cy >>> FRAC;
      exp_q.delete();
      area = edge_val(x0, y0, x1, y1, x2, y2);
      if (area == 0) return;
      lx = x0; if (x1 < lx) lx = x1; if (x2 < lx) lx = x2; if (lx < 0) lx = 0;
      hx = x0; if (x1 > hx) hx = x1; if (x2 > hx) hx = x2; if (hx > 319) hx = 319;
      ly = y0; if (y1 < ly) ly = y1; if (y2 < ly) ly = y2; if (ly < 0) ly = 0;
      hy = y0; if (y1 > hy) hy = y1; if (y2 > hy) hy = y2; if (hy > 239) hy = 239;
      for (longint y = ly; y <= hy; y++) begin
         for (longint x = lx; x <= hx; x++) begin
            e0 = edge_val(x0, y0, x1, y1, x, y);
            e1 = edge_val(x1, y1, x2, y2, x, y);
            e2 = edge_val(x2, y2, x0, y0, x, y);
            if ((area > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                (area < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
               px = 9'(x);
               py = 9'(y);
               exp_q.push_back({px, py});
            end
         end
      end
   endtask

   // Starts one triangle and collects accepted coords into got_q. done_cycle
   // is the cycle index of done counted from the start-sampling cycle (0).
   task automatic run_tri(input int ax, ay, bx, by, cx, cy,
                          input int ready_pct, input int stall_first,
                          input bit noise, input string name);
      int          k;
      int          stall_left;
      bit          saw_done;
      bit          prev_stall;
      bit          r;
      logic [17:0] prev_coord;
      got_q.delete();
      done_cycle = -1;
      saw_done   = 1'b0;
      prev_stall = 1'b0;
      prev_coord = '0;
      stall_left = stall_first;
      V0X = ax; V0Y = ay; V1X = bx; V1Y = by; V2X = cx; V2Y = cy;
      @(negedge CLOCK_50);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      k = 1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL %s busy_setup got %b want 1", name, busy);
      end
      while (k <= BUDGET) begin
         if (done === 1'b1) begin
            saw_done   = 1'b1;
            done_cycle = k;
            n_checks++;
            if (coord_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL %s done_with_valid got valid %b want 0", name, coord_valid);
            end
            break;
         end
         if (prev_stall) begin
            n_checks++;
            if (coord_valid !== 1'b1 || coord !== prev_coord) begin
               n_errors++;
               $display("FAIL %s hold got valid %b coord %h want 1 %h",
                        name, coord_valid, coord, prev_coord);
            end
         end
         if (coord_valid === 1'b1) begin
            if (stall_left > 0) begin
               r = 1'b0;
               stall_left--;
            end else begin
               r = ($urandom_range(99) < ready_pct);
            end
            coord_ready = r;
            if (r) got_q.push_back(coord);
            prev_stall = !r;
            prev_coord = coord;
         end else begin
            coord_ready = 1'($urandom_range(1));
            prev_stall  = 1'b0;
         end
         if (noise) begin
            start = 1'($urandom_range(1));
            V0X = $urandom; V0Y = $urandom; V1X = $urandom;
            V1Y = $urandom; V2X = $urandom; V2Y = $urandom;
         end
         @(negedge CLOCK_50);
         k++;
      end
      start       = 1'b0;
      coord_ready = 1'b0;
      n_checks++;
      if (!saw_done) begin
         n_errors++;
         $display("FAIL %s timeout got no done want done within %0d cycles", name, BUDGET);
      end else begin
         @(negedge CLOCK_50);
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s after_done got done %b busy %b want 0 0", name, done, busy);
         end
      end
   endtask

   task automatic compare_q(input string name);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_errors++;
         $display("FAIL %s count got %0d want %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_errors++;
            $display("FAIL %s coord[%0d] got %h want %h", name, i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      #23;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || coord_valid !== 1'b0 || coord !== 18'h0) begin
         n_errors++;
         $display("FAIL reset_state got busy %b done %b valid %b coord %h want 0 0 0 00000",
                  busy, done, coord_valid, coord);
      end
      @(negedge CLOCK_50);
      RESET_N = 1'b1;
      @(negedge CLOCK_50);
      n_checks++;
      if (busy !== 1'b0 || coord_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release got busy %b valid %b want 0 0", busy, coord_valid);
      end
   endtask

   task automatic test_basic();
      run_tri(fx(0), fx(0), fx(4), fx(0), fx(0), fx(4), 100, 0, 1'b0, "basic");
      n_checks++;
      if (got_q.size() != 15 || got_q[0] !== 18'h00000 || got_q[1] !== 18'h00200 ||
          got_q[2] !== 18'h00400 || got_q[14] !== 18'h00004) begin
         n_errors++;
         $display("FAIL basic_fixed got n %0d first %h last %h want 15 00000 00004",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h3ffff,
                  (got_q.size() > 0) ? got_q[got_q.size()-1] : 18'h3ffff);
      end
      build_expected(fx(0), fx(0), fx(4), fx(0), fx(0), fx(4));
      compare_q("basic");
      ref_q = got_q;
   endtask

   task automatic test_reverse();
      run_tri(fx(0), fx(0), fx(0), fx(4), fx(4), fx(0), 100, 0, 1'b0, "reverse");
      exp_q = ref_q;
      compare_q("reverse");
   endtask

   task automatic test_degenerate();
      run_tri(fx(0), fx(0), fx(2), fx(2), fx(4), fx(4), 100, 0, 1'b0, "collinear");
      n_checks++;
      if (done_cycle != 3 || got_q.size() != 0) begin
         n_errors++;
         $display("FAIL collinear got done_cycle %0d coords %0d want 3 0", done_cycle, got_q.size());
      end
      run_tri(32'hFFFB0000, fx(0), 32'hFFFB0000, fx(5), 32'hFFFB0000, fx(9),
              100, 0, 1'b0, "offscreen");
      n_checks++;
      if (done_cycle != 3 || got_q.size() != 0) begin
         n_errors++;
         $display("FAIL offscreen got done_cycle %0d coords %0d want 3 0", done_cycle, got_q.size());
      end
   endtask

   task automatic test_clip();
      bit neg_x;
      run_tri(fx(-4), fx(0), fx(4), fx(0), fx(0), fx(4), 100, 0, 1'b0, "clip");
      build_expected(fx(-4), fx(0), fx(4), fx(0), fx(0), fx(4));
      compare_q("clip");
      neg_x = 1'b0;
      foreach (got_q[i]) if (got_q[i][17:9] > 9'd319) neg_x = 1'b1;
      n_checks++;
      if (got_q.size() != 15 || neg_x) begin
         n_errors++;
         $display("FAIL clip_fixed got n %0d wrapped_x %b want 15 0", got_q.size(), neg_x);
      end
      // Far-away vertices exercise the full-width edge arithmetic.
      run_tri(fx(-60000), fx(10), fx(60000), fx(12), fx(100), fx(14), 100, 0, 1'b0, "far");
      build_expected(fx(-60000), fx(10), fx(60000), fx(12), fx(100), fx(14));
      compare_q("far");
   endtask

   task automatic test_backpressure();
      run_tri(fx(0), fx(0), fx(4), fx(0), fx(0), fx(4), 100, 5, 1'b0, "backpressure");
      exp_q = ref_q;
      compare_q("backpressure");
   endtask

   task automatic test_busy_start();
      run_tri(fx(0), fx(0), fx(4), fx(0), fx(0), fx(4), 70, 0, 1'b1, "busy_start");
      exp_q = ref_q;
      compare_q("busy_start");
   endtask

   task automatic test_abort_reset();
      int cnt;
      int k;
      cnt = 0;
      V0X = fx(0); V0Y = fx(0); V1X = fx(4); V1Y = fx(0); V2X = fx(0); V2Y = fx(4);
      coord_ready = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      k = 0;
      while (k < 200 && !(coord_valid === 1'b1 && cnt == 6)) begin
         if (coord_valid === 1'b1) cnt++;
         @(negedge CLOCK_50);
         k++;
      end
      n_checks++;
      if (cnt != 6) begin
         n_errors++;
         $display("FAIL abort_reach got accepted %0d want 6", cnt);
      end
      coord_ready = 1'b0;
      #2 RESET_N = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || coord_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_async got busy %b done %b valid %b want 0 0 0",
                  busy, done, coord_valid);
      end
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      RESET_N = 1'b1;
      @(negedge CLOCK_50);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || coord_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_idle got busy %b done %b valid %b want 0 0 0",
                  busy, done, coord_valid);
      end
      run_tri(fx(0), fx(0), fx(4), fx(0), fx(0), fx(4), 100, 0, 1'b0, "after_abort");
      exp_q = ref_q;
      compare_q("after_abort");
   endtask

   task automatic test_random();
      int cx, cy;
      int v[6];
      for (int t = 0; t < 8; t++) begin
         cx = $urandom_range(360) - 20;
         cy = $urandom_range(280) - 20;
         for (int i = 0; i < 3; i++) begin
            v[2*i]   = fx(cx + $urandom_range(40) - 20) | int'($urandom_range(32767));
            v[2*i+1] = fx(cy + $urandom_range(40) - 20) | int'($urandom_range(32767));
         end
         run_tri(v[0], v[1], v[2], v[3], v[4], v[5], 30 + $urandom_range(70), 0, 1'b0, "random");
         build_expected(v[0], v[1], v[2], v[3], v[4], v[5]);
         compare_q("random");
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 3; t++) begin
         run_tri(fx(t), fx(0), fx(t + 4), fx(0), fx(t), fx(4), 100, 0, 1'b0, "back_to_back");
         build_expected(fx(t), fx(0), fx(t + 4), fx(0), fx(t), fx(4));
         compare_q("back_to_back");
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      start       = 1'b0;
      coord_ready = 1'b0;
      V0X = '0; V0Y = '0; V1X = '0; V1Y = '0; V2X = '0; V2Y = '0;
      test_reset();
      test_basic();
      test_reverse();
      test_degenerate();
      test_clip();
      test_backpressure();
      test_busy_start();
      test_abort_reset();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tri_bbox_raster.md
# tri_bbox_raster

Single-triangle rasterizer. Takes three screen-space vertices in 32-bit Q16.15 fixed point and scans the triangle's screen-clipped bounding box in row-major order using edge functions. It emits one packed pixel coordinate per covered pixel over a valid/ready stream. It sits upstream of the coordinate FIFO that the frame-buffer write FSM drains, and is started once per triangle by the polygon sequencer.

## Interface
- H_RES, 320: horizontal resolution; valid x is 0..H_RES-1.
- V_RES, 240: vertical resolution; valid y is 0..V_RES-1.
- FRAC_BITS, 15: fractional bits of the vertex fixed-point format.

Ports:
- CLOCK_50  in  1: single clock; all logic on the rising edge.
- RESET_N  in  1: asynchronous, active-low reset.
- start  in  1: one-cycle start pulse. Sampled only in IDLE.
- V0X, V0Y, V1X, V1Y, V2X, V2Y  in  32 each: vertex coordinates, signed Q16.15. Latched on an accepted start.
- busy  out  1: high whenever the state is not IDLE.
- done  out  1: one-cycle pulse when the triangle is finished.
- coord_valid  out  1: coord holds a covered pixel.
- coord  out  18: {x[8:0], y[8:0]}; x is in coord[17:9], y is in coord[8:0].
- coord_ready  in  1: consumer accepts coord when coord_valid & coord_ready.

## Operation
- Vertex conversion: integer part = V >>> FRAC_BITS (arithmetic shift), kept as 17-bit signed. The fraction is discarded.
- Edge function for edge a→b at pixel p: E = (px−ax)·(by−ay) − (py−ay)·(bx−ax).
  - Differences are 18-bit signed.
  - Products are 36-bit signed.
  - E is 37-bit signed.
  - There is no overflow for any 32-bit input.
- The three edges are v0→v1, v1→v2, and v2→v0.
- Area term A = E of edge v0→v1 evaluated at v2.
  - A = 0: the triangle is degenerate and emits no pixels.
  - A < 0: set the flip flag, which negates all three E values before testing.
- Coverage test: a pixel is inside when all three (possibly negated) E values are ≥ 0.
  - Edges are inclusive.
  - Sampling is at integer pixel coordinates.
  - Both windings give identical pixel sets.
- Bounding box:
  - xmin = max(min(x0,x1,x2), 0)
  - xmax = min(max(x0,x1,x2), H_RES−1)
  - ymin and ymax are computed the same way against V_RES−1.
  - If xmin > xmax or ymin > ymax, no pixels are emitted.
- Scan order: for y = ymin..ymax, for x = xmin..xmax.
- States:
  - IDLE: wait for start. On start, latch the vertices and go to SETUP.
  - SETUP: compute integer vertices and the clamped bounding box; go to AREA.
  - AREA: compute A and flip. If A = 0 or the box is empty, go to DONE; otherwise set x=xmin, y=ymin and go to SCAN.
  - SCAN: evaluate the pixel at (x,y).
    - Inside: register coord and go to EMIT.
    - Outside: advance.
  - EMIT: hold coord_valid=1 with coord stable until the handshake completes, then advance.
  - Advance:
    - If x < xmax, x++ and go to SCAN.
    - Else if y < ymax, x=xmin, y++ and go to SCAN.
    - Else go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- start asserted while busy is ignored. Vertex input changes after latching are ignored.
- Reset values: state=IDLE; busy=0, done=0, coord_valid=0, coord=0. Internal registers are 0.
- Asserting RESET_N low mid-scan aborts immediately. A pixel that has not been accepted is discarded, with no partial done.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: SETUP, busy=1.
- Cycle 2: AREA.
- Cycle 3: first SCAN.
- Degenerate or empty triangle: done is high in cycle 3 and busy drops in cycle 4.
- Outside pixel: costs 1 cycle.
- Inside pixel: costs 1 SCAN cycle plus at least 1 EMIT cycle. coord_valid rises the cycle after SCAN.
- Backpressure: while coord_ready=0, coord_valid stays 1 and coord is unchanged. coord_valid never drops before acceptance.
- After the final accepted pixel, DONE is the next cycle. done and coord_valid are never high together.
- busy is high during the DONE cycle. A new start is accepted from the cycle after done.

## Test plan
- Vertices (0,0),(4,0),(0,4), i.e. 0x00000000 / 0x00020000, with coord_ready=1 → exactly 15 coords:
  - Order begins 0x00000, 0x00200, 0x00400 …
  - Last coord is 0x00004 (x=0, y=4).
  - Then one done pulse.
- Same vertices in reverse winding (0,0),(0,4),(4,0) → the identical 15-coord sequence.
- Collinear (0,0),(2,2),(4,4) → no coord_valid; done in cycle 3 after start.
- Clipping:
  - (−4,0),(4,0),(0,4) → 15 coords, all with x ≥ 0.
  - All vertices at x=−10 (0xFFFB0000) → zero coords, done in cycle 3.
- Backpressure: hold coord_ready=0 for 5 cycles when the first coord appears → coord stays 0x00000 with valid held; all 15 coords are still delivered in order.
- Assert RESET_N=0 during the 7th pixel → busy, done, and coord_valid go 0 asynchronously. A fresh start after release yields the full 15-coord sequence.
